mult_iterative: RTL and testbench

//  Multi-cycle radix-2 shift-add multiplier for the RV32M MUL/MULH/MULHSU/MULHU group.

---
 rtl/mult_iterative_pkg.sv | 15 +
 rtl/mult_iterative.sv | 105 ++++++++++
 tb/tb_mult_iterative.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/mult_iterative_pkg.sv
// rtl/mult_iterative_pkg.sv - shared word types and FSM state encoding for the iterative multiplier
package mult_iterative_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0]   word_t;
  typedef logic [2*WORD_W-1:0] dword_t;

  typedef enum logic [1:0] {
    MULT_IDLE,
    MULT_CALC,
    MULT_FIN
  } mult_state_t;

endpackage

// File: rtl/mult_iterative.sv
// rtl/mult_iterative.sv - radix-2 shift-add multiplier for MUL/MULH/MULHSU/MULHU
// Define MULT_EARLY_OUT_EN to leave CALC as soon as the remaining multiplier bits are all zero.
module mult_iterative
  import mult_iterative_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             flush,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mult_half,
  input  logic             mult_signed_a,
  input  logic             mult_signed_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  mult_state_t        state;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplr;
  logic [CNT_W-1:0]   cnt;
  logic               neg;
  logic               half_q;

  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH-1:0] prod;
  logic               early_exit;

  // Signed operands are reduced to magnitudes; the sign is reapplied to the full product in FIN.
  assign a_neg = mult_signed_a & a[WIDTH-1];
  assign b_neg = mult_signed_b & b[WIDTH-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;
  assign prod  = neg ? -acc : acc;

`ifdef MULT_EARLY_OUT_EN
  assign early_exit = (mplr == '0);
`else
  assign early_exit = 1'b0;
`endif

  assign busy = (state != MULT_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= MULT_IDLE;
      done   <= 1'b0;
      result <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplr   <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      half_q <= 1'b0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        state <= MULT_IDLE;
      end else begin
        case (state)
          MULT_IDLE: begin
            if (start) begin
              mcand  <= {{WIDTH{1'b0}}, a_mag};
              mplr   <= b_mag;
              neg    <= a_neg ^ b_neg;
              half_q <= mult_half;
              acc    <= '0;
              cnt    <= '0;
              state  <= MULT_CALC;
            end
          end
          MULT_CALC: begin
            if (early_exit) begin
              state <= MULT_FIN;
            end else begin
              if (mplr[0]) acc <= acc + mcand;
              mcand <= mcand << 1;
              mplr  <= mplr >> 1;
              cnt   <= cnt + CNT_W'(1);
              if (cnt == CNT_LAST) state <= MULT_FIN;
            end
          end
          MULT_FIN: begin
            result <= half_q ? prod[2*WIDTH-1:WIDTH] : prod[WIDTH-1:0];
            done   <= 1'b1;
            state  <= MULT_IDLE;
          end
          default: state <= MULT_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mult_iterative.sv
// tb/tb_mult_iterative.sv - directed self-checking bench for mult_iterative
module tb_mult_iterative;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        flush;
  logic [31:0] a;
  logic [31:0] b;
  logic        mult_half;
  logic        mult_signed_a;
  logic        mult_signed_b;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int tests = 0;
  int fails = 0;

  mult_iterative #(.WIDTH(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .flush         (flush),
    .a             (a),
    .b             (b),
    .mult_half     (mult_half),
    .mult_signed_a (mult_signed_a),
    .mult_signed_b (mult_signed_b),
    .busy          (busy),
    .done          (done),
    .result        (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Launches one multiply and measures latency in cycles from the sampling cycle N to the done cycle.
  // With b2b set the caller is already mid-cycle (the done cycle) and start is driven there.
  task automatic do_mul(input string tag, input logic [31:0] va, input logic [31:0] vb,
                        input logic h, input logic sa, input logic sb,
                        input logic [31:0] exp_res, input int exp_lat, input bit b2b);
    int lat;
    bit seen;
    if (!b2b) @(negedge clk);
    a = va; b = vb; mult_half = h; mult_signed_a = sa; mult_signed_b = sb;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = $urandom; b = $urandom; mult_half = ~h; mult_signed_a = ~sa; mult_signed_b = ~sb;
    lat = 1;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      lat++;
    end
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_result"}, 64'(result), 64'(exp_res));
  endtask

  int lat_m3, lat_full, lat_b0, lat_b1, lat_b5;
  logic [31:0] held;
  bit stray_done;

  initial begin
`ifdef MULT_EARLY_OUT_EN
    lat_m3 = 5; lat_full = 34; lat_b0 = 3; lat_b1 = 4; lat_b5 = 6;
`else
    lat_m3 = 34; lat_full = 34; lat_b0 = 34; lat_b1 = 34; lat_b5 = 34;
`endif
    rst = 1'b1; start = 1'b0; flush = 1'b0; a = '0; b = '0;
    mult_half = 1'b0; mult_signed_a = 1'b0; mult_signed_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_result", 64'(result), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    do_mul("s7xm3", 32'd7, 32'hFFFF_FFFD, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFEB, lat_m3, 1'b0);
    @(negedge clk);
    check("done_one_cycle", 64'(done), 64'd0);
    check("idle_after_done", 64'(busy), 64'd0);

    do_mul("uu_ff_hi", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFE, lat_full, 1'b0);
    do_mul("uu_ff_lo", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 32'h0000_0001, lat_full, 1'b0);
    do_mul("ss_min_hi", 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 1'b1, 32'h4000_0000, lat_full, 1'b0);
    do_mul("su_hi", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF, lat_full, 1'b0);

    // Flush at N+10 with an ignored start at N+5.
    held = result;
    @(negedge clk);
    a = 32'd9; b = 32'hFFFF_0000; mult_half = 1'b0; mult_signed_a = 1'b0; mult_signed_b = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("flush_busy_before", 64'(busy), 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy_after", 64'(busy), 64'd0);
    stray_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) stray_done = 1'b1;
    end
    check("flush_no_done", 64'(stray_done), 64'd0);
    check("flush_result_held", 64'(result), 64'(held));

    // Flush and start together in IDLE: nothing launches.
    @(negedge clk);
    start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("flush_beats_start", 64'(busy), 64'd0);

    do_mul("b_zero", 32'h1234_5678, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, lat_b0, 1'b0);
    do_mul("b_one", 32'h1234_5678, 32'd1, 1'b0, 1'b0, 1'b0, 32'h1234_5678, lat_b1, 1'b0);
    do_mul("b2b", 32'd12345, 32'h8000_0000, 1'b1, 1'b0, 1'b0, 32'h0000_181C, lat_full, 1'b1);

    // Asynchronous reset in the middle of CALC.
    @(negedge clk);
    a = 32'd3; b = 32'd5; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_result", 64'(result), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    do_mul("after_rst", 32'd3, 32'd5, 1'b0, 1'b0, 1'b0, 32'd15, lat_b5, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
